psw_cex_unit: RTL and testbench

Holds the architectural Program Status Word and applies the value/mask flag updates produced by the execute-stage flag logic. Also evaluates CEX (conditional execution) conditions against the stored flags. It runs the true/false instruction-window state machine that tells the execute stage whether each retiring instruction may commit. It sits in the execute stage, downstream of the flag-update logic and upstream of writeback.

---
 rtl/psw_cex_unit.sv | 125 ++++++++++++
 tb/tb_psw_cex_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/psw_cex_unit.sv
// Program Status Word register with masked flag updates, plus the CEX true/false
// window state machine that decides whether each retiring instruction may commit.
module psw_cex_unit #(
  parameter logic [15:0] PSW_RESET = 16'h0000,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      psw_in,
  input  logic [15:0]      psw_msk,
  input  logic             psw_wr_en,
  input  logic             psw_load,
  input  logic [15:0]      psw_load_val,
  input  logic             cex_valid,
  input  logic [3:0]       cex_cond,
  input  logic [CNT_W-1:0] cex_tc,
  input  logic [CNT_W-1:0] cex_fc,
  input  logic             instr_retire,
  output logic [15:0]      psw,
  output logic             exec_allow,
  output logic             cex_active
);

  typedef enum logic [2:0] {StIdle, StExecT, StSkipF, StSkipT, StExecF} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic [15:0]      psw_q, psw_d;
  logic             active_q;
  logic             cond_true;
  logic             flag_c, flag_z, flag_n, flag_v;

  assign flag_c = psw_q[0];
  assign flag_z = psw_q[1];
  assign flag_n = psw_q[2];
  assign flag_v = psw_q[4];

  // Conditions look at the registered flags only, never a same-cycle write.
  always_comb begin
    cond_true = 1'b0;
    case (cex_cond)
      4'h0: cond_true = flag_z;
      4'h1: cond_true = !flag_z;
      4'h2: cond_true = flag_c;
      4'h3: cond_true = !flag_c;
      4'h4: cond_true = flag_n;
      4'h5: cond_true = !flag_n;
      4'h6: cond_true = flag_v;
      4'h7: cond_true = !flag_v;
      4'h8: cond_true = flag_c && !flag_z;
      4'h9: cond_true = !flag_c || flag_z;
      4'hA: cond_true = (flag_n == flag_v);
      4'hB: cond_true = (flag_n != flag_v);
      4'hC: cond_true = !flag_z && (flag_n == flag_v);
      4'hD: cond_true = flag_z || (flag_n != flag_v);
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign exec_allow = (state_q == StIdle) || (state_q == StExecT) || (state_q == StExecF);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    if (psw_load) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (cex_valid && exec_allow) begin
      // An allowed CEX always restarts the window, discarding any current one.
      fc_d = cex_fc;
      if (cex_tc != '0) begin
        state_d = cond_true ? StExecT : StSkipT;
        cnt_d   = cex_tc;
      end else if (cex_fc != '0) begin
        state_d = cond_true ? StSkipF : StExecF;
        cnt_d   = cex_fc;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else if ((cex_valid || instr_retire) && (state_q != StIdle)) begin
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (((state_q == StExecT) || (state_q == StSkipT)) && (fc_q != '0)) begin
        state_d = (state_q == StExecT) ? StSkipF : StExecF;
        cnt_d   = fc_q;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    psw_d = psw_q;
    if (psw_load) begin
      psw_d = psw_load_val;
    end else if (psw_wr_en && exec_allow) begin
      psw_d[4:0] = (psw_q[4:0] & ~psw_msk[4:0]) | (psw_in[4:0] & psw_msk[4:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      fc_q     <= '0;
      psw_q    <= PSW_RESET;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fc_q     <= fc_d;
      psw_q    <= psw_d;
      active_q <= (state_d != StIdle);
    end
  end

  assign psw        = psw_q;
  assign cex_active = active_q;

endmodule

// File: tb/tb_psw_cex_unit.sv
// Table-driven bench for psw_cex_unit: per-cycle vectors with hand-derived expectations,
// post-edge results held in a scoreboard queue, plus a hand-written mid-window reset.
module tb_psw_cex_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] psw_in, psw_msk, psw_load_val;
  logic        psw_wr_en, psw_load;
  logic        cex_valid, instr_retire;
  logic [3:0]  cex_cond;
  logic [2:0]  cex_tc, cex_fc;
  logic [15:0] psw;
  logic        exec_allow, cex_active;

  psw_cex_unit #(
    .PSW_RESET(16'h0000),
    .CNT_W    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .psw_in      (psw_in),
    .psw_msk     (psw_msk),
    .psw_wr_en   (psw_wr_en),
    .psw_load    (psw_load),
    .psw_load_val(psw_load_val),
    .cex_valid   (cex_valid),
    .cex_cond    (cex_cond),
    .cex_tc      (cex_tc),
    .cex_fc      (cex_fc),
    .instr_retire(instr_retire),
    .psw         (psw),
    .exec_allow  (exec_allow),
    .cex_active  (cex_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] lv;
    logic        wr;
    logic [15:0] msk;
    logic [15:0] pin;
    logic        cv;
    logic [3:0]  cond;
    logic [2:0]  tc;
    logic [2:0]  fc;
    logic        ret;
    logic        allow;
    logic [15:0] epsw;
    logic        act;
  } vec_t;

  typedef struct {
    logic [15:0] epsw;
    logic        act;
    int          idx;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [15:0] cur;
  int          checks   = 0;
  int          failures = 0;

  function automatic void add(int load, logic [15:0] lv, int wr, logic [15:0] msk,
                              logic [15:0] pin, int cv, int cond, int tc, int fc, int ret,
                              int allow, int act);
    vec_t v;
    v.load  = 1'(load);
    v.lv    = lv;
    v.wr    = 1'(wr);
    v.msk   = msk;
    v.pin   = pin;
    v.cv    = 1'(cv);
    v.cond  = 4'(cond);
    v.tc    = 3'(tc);
    v.fc    = 3'(fc);
    v.ret   = 1'(ret);
    v.allow = 1'(allow);
    v.epsw  = cur;
    v.act   = 1'(act);
    vecs.push_back(v);
  endfunction

  function automatic void ret_v(int allow, int act);
    add(0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, allow, act);
  endfunction

  function automatic void cex_v(int cond, int tc, int fc, int allow, int act);
    add(0, 16'h0, 0, 16'h0, 16'h0, 1, cond, tc, fc, 0, allow, act);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, actual, expected);
    end
  endtask

  task automatic drive_idle();
    psw_in = '0; psw_msk = '0; psw_wr_en = 0; psw_load = 0; psw_load_val = '0;
    cex_valid = 0; cex_cond = '0; cex_tc = '0; cex_fc = '0; instr_retire = 0;
  endtask

  initial begin
    logic [15:0] sweep_psw [3];
    logic [15:0] sweep_true[3];
    logic [15:0] m;
    exp_t        e;

    // Flags (C,Z,N,V) = 0000, C+N, Z+V; bit c of the mask = condition c holds.
    sweep_psw[0] = 16'h0000; sweep_true[0] = 16'h56AA;
    sweep_psw[1] = 16'h0005; sweep_true[1] = 16'h6996;
    sweep_psw[2] = 16'h0012; sweep_true[2] = 16'h6A69;

    cur = 16'h0000;
    // Masked write, then a mask touching only bits 15:5.
    cur = 16'h0005; add(0, 16'h0, 1, 16'h0005, 16'h001F, 0, 0, 0, 0, 0, 1, 0);
    add(0, 16'h0, 1, 16'hFFE0, 16'h001F, 0, 0, 0, 0, 0, 1, 0);
    // Load beats a same-cycle masked write.
    cur = 16'hE0A3; add(1, 16'hE0A3, 1, 16'h001F, 16'h0000, 0, 0, 0, 0, 0, 1, 0);
    // EQ true (Z=1), tc=2 fc=1.
    cex_v(0, 2, 1, 1, 1);
    ret_v(1, 1); ret_v(1, 1); ret_v(0, 0); ret_v(1, 0);
    // N=1 V=0, GE false, tc=1 fc=2; write on the skipped slot is dropped.
    cur = 16'hE0A4; add(0, 16'h0, 1, 16'h001F, 16'h0004, 0, 0, 0, 0, 0, 1, 0);
    cex_v(4'hA, 1, 2, 1, 1);
    add(0, 16'h0, 1, 16'h0001, 16'h0001, 0, 0, 0, 0, 1, 0, 1);
    ret_v(1, 1); ret_v(1, 0);
    // Edge counts.
    cex_v(4'hE, 0, 0, 1, 0);
    cex_v(4'hF, 0, 3, 1, 1);
    ret_v(1, 1); ret_v(1, 1); ret_v(1, 0);
    cex_v(4'hE, 7, 7, 1, 1);
    for (int i = 0; i < 7; i++) ret_v(1, 1);
    for (int i = 0; i < 6; i++) ret_v(0, 1);
    ret_v(0, 0); ret_v(1, 0);
    // Load in slot 2 of a tc=5 window.
    cex_v(4'hE, 5, 0, 1, 1);
    ret_v(1, 1);
    cur = 16'h0003; add(1, 16'h0003, 0, 16'h0, 16'h0, 0, 0, 0, 0, 1, 1, 0);
    ret_v(1, 0);
    // Nested allowed CEX restarts with its own counts.
    cex_v(4'hE, 3, 2, 1, 1);
    ret_v(1, 1);
    cex_v(4'hF, 0, 1, 1, 1);
    ret_v(1, 0);
    // CEX in a skipped slot just consumes the slot.
    cex_v(4'hE, 1, 1, 1, 1);
    ret_v(1, 1);
    cex_v(4'hE, 3, 0, 0, 0);
    ret_v(1, 0);
    // CEX and retire together count as the CEX alone.
    add(0, 16'h0, 0, 16'h0, 16'h0, 1, 4'hE, 2, 0, 1, 1, 1);
    ret_v(1, 1); ret_v(1, 0);
    // Load wins over a same-cycle CEX.
    cur = 16'h0002; add(1, 16'h0002, 0, 16'h0, 16'h0, 1, 4'hE, 3, 0, 0, 1, 0);
    ret_v(1, 0);
    // Condition sweep: tc=1 fc=0, the following slot is allowed iff the condition held.
    for (int p = 0; p < 3; p++) begin
      cur = sweep_psw[p];
      m   = sweep_true[p];
      add(1, sweep_psw[p], 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 0);
      for (int c = 0; c < 16; c++) begin
        cex_v(c, 1, 0, 1, 1);
        ret_v(int'(m[c]), 0);
      end
    end

    drive_idle();
    rst = 1'b1;
    #12;
    chk("reset_psw", -1, 32'(psw), 32'h0000);
    chk("reset_active", -1, 32'(cex_active), 32'h0);
    chk("reset_allow", -1, 32'(exec_allow), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      psw_load = vecs[i].load; psw_load_val = vecs[i].lv;
      psw_wr_en = vecs[i].wr; psw_msk = vecs[i].msk; psw_in = vecs[i].pin;
      cex_valid = vecs[i].cv; cex_cond = vecs[i].cond;
      cex_tc = vecs[i].tc; cex_fc = vecs[i].fc; instr_retire = vecs[i].ret;
      #1;
      chk("exec_allow", i, 32'(exec_allow), 32'(vecs[i].allow));
      sb.push_back('{epsw: vecs[i].epsw, act: vecs[i].act, idx: i});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("psw", e.idx, 32'(psw), 32'(e.epsw));
      chk("cex_active", e.idx, 32'(cex_active), 32'(e.act));
    end

    // Reset pulse in the middle of a window clears it immediately.
    @(negedge clk);
    drive_idle();
    cex_valid = 1; cex_cond = 4'hE; cex_tc = 3'd4;
    @(posedge clk);
    #1;
    chk("midrst_enter", -2, 32'(cex_active), 32'h1);
    @(negedge clk);
    drive_idle();
    instr_retire = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    instr_retire = 0;
    rst = 1'b1;
    #1;
    chk("midrst_psw", -2, 32'(psw), 32'h0000);
    chk("midrst_active", -2, 32'(cex_active), 32'h0);
    chk("midrst_allow", -2, 32'(exec_allow), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    instr_retire = 1;
    @(posedge clk);
    #1;
    chk("postrst_active", -2, 32'(cex_active), 32'h0);
    chk("postrst_allow", -2, 32'(exec_allow), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
